// File: rtl/instruction_decode.sv
// Instruction decode stage: RV32I decoder, 32x32 register file with optional
// writeback bypass, load-use hazard detection and the ID/EX pipeline register.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_pc, if_pc_inc, if_instr   IF/ID contents (32'h0 instruction = bubble)
//   stall_execute, flush_execute hold / bubble the ID/EX register
//   wb_we, wb_rd, wb_data        register-file write port
//   load_use_stall               combinational stall request to fetch/decode
//   ex_*                         ID/EX register outputs (PCs, indices,
//                                operands, immediate, ALU op, control flags)
module instruction_decode #(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_pc_inc,
  input  logic [31:0] if_instr,
  input  logic        stall_execute,
  input  logic        flush_execute,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        load_use_stall,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_pc_inc,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [3:0]  ex_alu_op,
  output logic [2:0]  ex_funct3,
  output logic        ex_reg_we,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_jal,
  output logic        ex_jalr,
  output logic        ex_alu_src_imm,
  output logic        ex_op_a_pc,
  output logic        ex_illegal
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;
  localparam int unsigned NREG = 32;
  localparam int unsigned ALUW = 4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [ALUW-1:0] ALU_ADD    = 4'd0;
  localparam logic [ALUW-1:0] ALU_SUB    = 4'd1;
  localparam logic [ALUW-1:0] ALU_SLL    = 4'd2;
  localparam logic [ALUW-1:0] ALU_SLT    = 4'd3;
  localparam logic [ALUW-1:0] ALU_SLTU   = 4'd4;
  localparam logic [ALUW-1:0] ALU_XOR    = 4'd5;
  localparam logic [ALUW-1:0] ALU_SRL    = 4'd6;
  localparam logic [ALUW-1:0] ALU_SRA    = 4'd7;
  localparam logic [ALUW-1:0] ALU_OR     = 4'd8;
  localparam logic [ALUW-1:0] ALU_AND    = 4'd9;
  localparam logic [ALUW-1:0] ALU_PASS_B = 4'd10;

  typedef struct packed {
    logic            valid;
    logic            reg_we;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            alu_src_imm;
    logic            op_a_pc;
    logic            illegal;
    logic [ALUW-1:0] alu_op;
  } ctrl_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [REGW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = if_instr[6:0];
  assign funct3 = if_instr[14:12];
  assign rd     = if_instr[11:7];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];

  assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
  assign imm_u = {if_instr[31:12], 12'h000};
  assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

  // Register file: x0 is never written and always reads as zero
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rs1_data, rs2_data;

  always_ff @(posedge clk) begin
    if (wb_we && (wb_rd != '0)) rf_q[wb_rd] <= wb_data;
  end

  // Read ports, with same-cycle writeback forwarding when enabled
  always_comb begin
    rs1_data = (rs1 == '0) ? '0 : rf_q[rs1];
    rs2_data = (rs2 == '0) ? '0 : rf_q[rs2];
    if (WB_BYPASS && wb_we && (wb_rd == rs1) && (rs1 != '0)) rs1_data = wb_data;
    if (WB_BYPASS && wb_we && (wb_rd == rs2) && (rs2 != '0)) rs2_data = wb_data;
  end

  // ALU op from funct3; instr[30] selects SUB only for register-register ops
  logic [ALUW-1:0] alu_f3;

  always_comb begin
    alu_f3 = ALU_ADD;
    case (funct3)
      3'b000:  alu_f3 = ((opcode == OPC_OP) && if_instr[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = if_instr[30] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  end

  // Main decoder
  ctrl_t           dec;
  logic [XLEN-1:0] dec_imm;
  logic            rs1_used, rs2_used;
  logic            rd_nz;

  assign rd_nz = (rd != '0);

  always_comb begin
    dec       = '0;
    dec_imm   = '0;
    rs1_used  = 1'b1;
    rs2_used  = 1'b0;
    dec.valid = (if_instr != '0);
    case (opcode)
      OPC_LUI: begin
        dec.alu_op      = ALU_PASS_B;
        dec.alu_src_imm = 1'b1;
        dec.reg_we      = rd_nz;
        dec_imm         = imm_u;
        rs1_used        = 1'b0;
      end
      OPC_AUIPC: begin
        dec.alu_src_imm = 1'b1;
        dec.op_a_pc     = 1'b1;
        dec.reg_we      = rd_nz;
        dec_imm         = imm_u;
        rs1_used        = 1'b0;
      end
      OPC_JAL: begin
        dec.jal    = 1'b1;
        dec.reg_we = rd_nz;
        dec_imm    = imm_j;
        rs1_used   = 1'b0;
      end
      OPC_JALR: begin
        dec.jalr        = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.reg_we      = rd_nz;
        dec_imm         = imm_i;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
        dec_imm    = imm_b;
        rs2_used   = 1'b1;
      end
      OPC_LOAD: begin
        dec.mem_read    = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.reg_we      = rd_nz;
        dec_imm         = imm_i;
      end
      OPC_STORE: begin
        dec.mem_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec_imm         = imm_s;
        rs2_used        = 1'b1;
      end
      OPC_OPIMM: begin
        dec.alu_op      = alu_f3;
        dec.alu_src_imm = 1'b1;
        dec.reg_we      = rd_nz;
        dec_imm         = imm_i;
      end
      OPC_OP: begin
        dec.alu_op = alu_f3;
        dec.reg_we = rd_nz;
        rs2_used   = 1'b1;
      end
      // The all-zero word lands here too and stays a clean bubble
      default: dec.illegal = dec.valid;
    endcase
  end

  ctrl_t           ctrl_q, ctrl_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_inc_q, ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
  logic [REGW-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic [2:0]      ex_funct3_q;

  // A load in EX whose destination feeds the instruction now in decode
  assign load_use_stall = !stall_execute && ctrl_q.valid && ctrl_q.mem_read && (ex_rd_q != '0) &&
                          (((ex_rd_q == rs1) && rs1_used) || ((ex_rd_q == rs2) && rs2_used));

  // ID/EX control next state: flush > hold > hazard bubble > load
  always_comb begin
    ctrl_d = ctrl_q;
    if (flush_execute)       ctrl_d = '0;
    else if (stall_execute)  ctrl_d = ctrl_q;
    else if (load_use_stall) ctrl_d = '0;
    else                     ctrl_d = dec;
  end

  always_ff @(posedge clk) begin
    if (rst) ctrl_q <= '0;
    else     ctrl_q <= ctrl_d;
  end

  // Data fields are don't-care under a bubble, so they only honour the hold
  always_ff @(posedge clk) begin
    if (!stall_execute) begin
      ex_pc_q       <= if_pc;
      ex_pc_inc_q   <= if_pc_inc;
      ex_rs1_q      <= rs1;
      ex_rs2_q      <= rs2;
      ex_rd_q       <= rd;
      ex_rs1_data_q <= rs1_data;
      ex_rs2_data_q <= rs2_data;
      ex_imm_q      <= dec_imm;
      ex_funct3_q   <= funct3;
    end
  end

  assign ex_valid       = ctrl_q.valid;
  assign ex_reg_we      = ctrl_q.reg_we;
  assign ex_mem_read    = ctrl_q.mem_read;
  assign ex_mem_write   = ctrl_q.mem_write;
  assign ex_branch      = ctrl_q.branch;
  assign ex_jal         = ctrl_q.jal;
  assign ex_jalr        = ctrl_q.jalr;
  assign ex_alu_src_imm = ctrl_q.alu_src_imm;
  assign ex_op_a_pc     = ctrl_q.op_a_pc;
  assign ex_illegal     = ctrl_q.illegal;
  assign ex_alu_op      = ctrl_q.alu_op;
  assign ex_pc          = ex_pc_q;
  assign ex_pc_inc      = ex_pc_inc_q;
  assign ex_rs1         = ex_rs1_q;
  assign ex_rs2         = ex_rs2_q;
  assign ex_rd          = ex_rd_q;
  assign ex_rs1_data    = ex_rs1_data_q;
  assign ex_rs2_data    = ex_rs2_data_q;
  assign ex_imm         = ex_imm_q;
  assign ex_funct3      = ex_funct3_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Testbench for instruction_decode: directed scenarios followed by random
// instruction streams, checked against an instruction-level reference model.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, if_pc_inc, if_instr;
  logic        stall_execute, flush_execute;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        load_use_stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_pc_inc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_funct3;
  logic        ex_reg_we, ex_mem_read, ex_mem_write, ex_branch, ex_jal, ex_jalr;
  logic        ex_alu_src_imm, ex_op_a_pc, ex_illegal;

  always #5 clk = ~clk;

  instruction_decode #(.WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_pc_inc(if_pc_inc), .if_instr(if_instr),
    .stall_execute(stall_execute), .flush_execute(flush_execute),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .load_use_stall(load_use_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc_inc(ex_pc_inc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3),
    .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_alu_src_imm(ex_alu_src_imm), .ex_op_a_pc(ex_op_a_pc), .ex_illegal(ex_illegal)
  );

  // Expected ID/EX contents; chk_* clear where the value is left open
  typedef struct {
    logic        valid;
    logic [31:0] pc, pc_inc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic        reg_we, mem_read, mem_write, branch, jal, jalr, src, opa, illegal;
    bit          chk_imm, chk_alu, chk_src, chk_opa, rs1_used, rs2_used;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rfm [32];
  exp_t        ex_m;
  bit          live = 1'b0;
  logic        last_lus;
  logic [31:0] cur_pc = 32'h0000_1000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] read_reg(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wb_we && wb_rd == r) return wb_data;
    return rfm[r];
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input bit is_op, input logic b30);
    int tbl[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    if (f3 == 3'd0 && is_op && b30) return 4'd1;
    if (f3 == 3'd5 && b30) return 4'd7;
    return 4'(tbl[f3]);
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e = '{default: '0};
    e.chk_src = 1'b1;
    e.chk_opa = 1'b1;
    return e;
  endfunction

  function automatic exp_t decode(input logic [31:0] ins);
    exp_t e;
    logic wr;
    e = '{default: '0};
    wr = (ins[11:7] != 5'd0);
    e.valid = (ins != 32'h0);
    e.pc = if_pc; e.pc_inc = if_pc_inc;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = ins[14:12];
    e.rs1d = read_reg(e.rs1); e.rs2d = read_reg(e.rs2);
    e.rs1_used = 1'b1;
    e.chk_imm = 1'b1; e.chk_alu = 1'b1; e.chk_src = 1'b1; e.chk_opa = 1'b1;
    case (ins[6:0])
      7'h37: begin e.imm = ins & 32'hFFFF_F000; e.alu = 4'd10; e.reg_we = wr; e.rs1_used = 1'b0; e.chk_src = 1'b0; end
      7'h17: begin e.imm = ins & 32'hFFFF_F000; e.opa = 1'b1; e.reg_we = wr; e.rs1_used = 1'b0; e.chk_src = 1'b0; end
      7'h6F: begin
        e.imm = 32'(($signed(ins) >>> 31) <<< 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        e.jal = 1'b1; e.reg_we = wr; e.rs1_used = 1'b0;
        e.chk_alu = 1'b0; e.chk_src = 1'b0; e.chk_opa = 1'b0;
      end
      7'h67: begin e.imm = 32'($signed(ins) >>> 20); e.jalr = 1'b1; e.src = 1'b1; e.reg_we = wr; end
      7'h63: begin
        e.imm = 32'(($signed(ins) >>> 31) <<< 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        e.branch = 1'b1; e.alu = 4'd1; e.rs2_used = 1'b1;
      end
      7'h03: begin e.imm = 32'($signed(ins) >>> 20); e.mem_read = 1'b1; e.src = 1'b1; e.reg_we = wr; end
      7'h23: begin
        e.imm = 32'(($signed(ins) >>> 25) <<< 5) | 32'(ins[11:7]);
        e.mem_write = 1'b1; e.src = 1'b1; e.rs2_used = 1'b1;
      end
      7'h13: begin e.imm = 32'($signed(ins) >>> 20); e.src = 1'b1; e.reg_we = wr; e.alu = alu_of(ins[14:12], 1'b0, ins[30]); end
      7'h33: begin e.imm = 32'h0; e.reg_we = wr; e.alu = alu_of(ins[14:12], 1'b1, ins[30]); e.rs2_used = 1'b1; end
      default: begin
        e.illegal = e.valid;
        e.chk_imm = 1'b0; e.chk_alu = 1'b0; e.chk_src = 1'b0; e.chk_opa = 1'b0;
      end
    endcase
    if (!e.valid) e.chk_alu = 1'b0;
    return e;
  endfunction

  task automatic compare_ex();
    check("ex_valid", 32'(ex_valid), 32'(ex_m.valid));
    check("flags", 32'({ex_reg_we, ex_mem_read, ex_mem_write, ex_branch, ex_jal, ex_jalr, ex_illegal}),
          32'({ex_m.reg_we, ex_m.mem_read, ex_m.mem_write, ex_m.branch, ex_m.jal, ex_m.jalr, ex_m.illegal}));
    if (ex_m.chk_src) check("alu_src_imm", 32'(ex_alu_src_imm), 32'(ex_m.src));
    if (ex_m.chk_opa) check("op_a_pc", 32'(ex_op_a_pc), 32'(ex_m.opa));
    if (ex_m.chk_alu) check("alu_op", 32'(ex_alu_op), 32'(ex_m.alu));
    if (ex_m.valid) begin
      check("ex_pc", ex_pc, ex_m.pc);
      check("ex_pc_inc", ex_pc_inc, ex_m.pc_inc);
      check("ex_regs", 32'({ex_rs1, ex_rs2, ex_rd}), 32'({ex_m.rs1, ex_m.rs2, ex_m.rd}));
      check("ex_rs1_data", ex_rs1_data, ex_m.rs1d);
      check("ex_rs2_data", ex_rs2_data, ex_m.rs2d);
      check("ex_funct3", 32'(ex_funct3), 32'(ex_m.f3));
      if (ex_m.chk_imm) check("ex_imm", ex_imm, ex_m.imm);
    end
  endtask

  // One clock: check the hazard output mid-cycle, advance the model, check ID/EX
  task automatic step();
    exp_t d, nx;
    logic lus;
    @(negedge clk);
    d = decode(if_instr);
    lus = !stall_execute && ex_m.valid && ex_m.mem_read && ex_m.rd != 5'd0 &&
          ((ex_m.rd == d.rs1 && d.rs1_used) || (ex_m.rd == d.rs2 && d.rs2_used));
    if (live) check("load_use_stall", 32'(load_use_stall), 32'(lus));
    last_lus = load_use_stall;
    if (rst) begin nx = bubble(); nx.chk_alu = 1'b1; end
    else if (flush_execute) nx = bubble();
    else if (stall_execute) nx = ex_m;
    else if (lus) nx = bubble();
    else nx = d;
    @(posedge clk);
    if (wb_we && wb_rd != 5'd0) rfm[wb_rd] = wb_data;
    ex_m = nx;
    live = 1'b1;
    #1;
    compare_ex();
  endtask

  task automatic drive(input logic [31:0] ins, input logic st, input logic fl,
                       input logic we, input logic [4:0] rd, input logic [31:0] data);
    rst = 1'b0;
    cur_pc = cur_pc + 32'd4;
    if_pc = cur_pc; if_pc_inc = cur_pc + 32'd4; if_instr = ins;
    stall_execute = st; flush_execute = fl;
    wb_we = we; wb_rd = rd; wb_data = data;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int k;
    logic [6:0] opcs[9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [6:0] bad[5]  = '{7'h7F, 7'h0F, 7'h73, 7'h0B, 7'h2F};
    w = $urandom;
    k = $urandom_range(0, 10);
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    if (k < 9) w[6:0] = opcs[k];
    else if (k == 9) w[6:0] = bad[$urandom_range(0, 4)];
    else w = 32'h0;
    return w;
  endfunction

  logic [31:0] held_pc, held_rs1d;

  initial begin
    ex_m = bubble();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    step();
    if_instr = 32'hFFF2_8313; stall_execute = 1'b1;
    step();
    check("rst_alu_op", 32'(ex_alu_op), 32'd0);

    // Populate the model's register file
    for (int r = 1; r < 32; r++) begin
      drive(32'h0, 1'b0, 1'b0, 1'b1, 5'(r), $urandom);
      step();
    end
    check("post_rst_lus", 32'(load_use_stall), 32'd0);

    // ADDI x6,x5,-1 after x5 = 0x1234
    drive(32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234);
    step();
    drive(32'hFFF2_8313, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("addi_rs1", ex_rs1_data, 32'h1234);
    check("addi_imm", ex_imm, 32'hFFFF_FFFF);
    check("addi_alu", 32'(ex_alu_op), 32'd0);
    check("addi_we", 32'(ex_reg_we), 32'd1);
    check("addi_rd", 32'(ex_rd), 32'd6);

    // ADD x8,x7,x0 with same-cycle write of x7
    drive(32'h0003_8433, 1'b0, 1'b0, 1'b1, 5'd7, 32'hCAFE);
    step();
    check("bypass_rs1", ex_rs1_data, 32'hCAFE);

    // LW x3,0(x1) then ADD x4,x3,x2
    drive(32'h0000_A183, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    drive(32'h0021_8233, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("lu_stall", 32'(last_lus), 32'd1);
    check("lu_bubble", 32'(ex_valid), 32'd0);
    step();
    check("lu_release", 32'(last_lus), 32'd0);
    check("lu_issue_v", 32'(ex_valid), 32'd1);
    check("lu_issue_rd", 32'(ex_rd), 32'd4);

    // BEQ -4 and an illegal opcode
    drive(32'hFE00_0EE3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("beq_imm", ex_imm, 32'hFFFF_FFFC);
    check("beq_branch", 32'(ex_branch), 32'd1);
    check("beq_we", 32'(ex_reg_we), 32'd0);
    drive(32'h0000_0FFF, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("ill_flag", 32'(ex_illegal), 32'd1);
    check("ill_we", 32'(ex_reg_we), 32'd0);

    // Three-cycle hold then flush
    drive(32'hFFF2_8313, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    held_pc = ex_pc;
    held_rs1d = ex_rs1_data;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0003_8433, 1'b1, 1'b0, 1'b1, 5'd5, $urandom);
      step();
      check("hold_pc", ex_pc, held_pc);
      check("hold_rs1", ex_rs1_data, held_rs1d);
    end
    drive(32'h0003_8433, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    step();
    check("flush_valid", 32'(ex_valid), 32'd0);

    // x0 ignores writes and is never forwarded
    drive(32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    drive(32'h0000_04B3, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD);
    step();
    check("x0_rs1", ex_rs1_data, 32'h0);
    check("x0_rs2", ex_rs2_data, 32'h0);

    // Reset during a hold clears the control state
    drive(32'hFFF2_8313, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    drive(32'hFFF2_8313, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    step();
    check("rst_stall_valid", 32'(ex_valid), 32'd0);

    // Random streams; decode is held while a load-use stall is requested
    drive(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      logic [31:0] pc_keep;
      pc_keep = if_pc;
      ins = last_lus ? if_instr : gen_instr();
      drive(ins, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      if (last_lus) begin
        if_pc = pc_keep;
        if_pc_inc = pc_keep + 32'd4;
      end
      rst = 1'($urandom_range(0, 99) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
